// File: rtl/rf_pkg.sv
// Shared register-file writeback types and sizing constants.
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NREQ_MAX   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus (requesters -> arbiter) plus the register-file write port.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
);
  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0][REG_ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][XLEN-1:0]       req_data;
  logic [NREQ-1:0]                 req_ready;
  logic                            hold;
  logic                            rd_wen;
  logic [REG_ADDR_W-1:0]           rd_addr;
  logic [XLEN-1:0]                 rd_data;

  modport master (
    output req_valid, req_addr, req_data, hold,
    input  req_ready, rd_wen, rd_addr, rd_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, hold,
    output req_ready, rd_wen, rd_addr, rd_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Grant selection for the writeback port. Round-robin when RF_WB_ARBITER_RR_EN
// is defined, otherwise a plain lowest-index-wins priority encoder.
module rr_arbiter #(
  parameter int NREQ = 3
) (
`ifdef RF_WB_ARBITER_RR_EN
  input  logic            clk,
  input  logic            rst,
`endif
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o
);

`ifdef RF_WB_ARBITER_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Two passes: indices at/after the pointer first, then the wrapped ones.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (PW'(i) >= ptr_q)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = (i == NREQ-1) ? '0 : PW'(i+1);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (PW'(i) < ptr_q)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          ptr_d    = (i == NREQ-1) ? '0 : PW'(i+1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one grant per cycle, one-cycle output stage.
// Arbitration policy selected by macro RF_WB_ARBITER_RR_EN (round-robin if defined).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  rf_wb_arbiter_if.slave  bus
);

  logic [NREQ-1:0]       gnt;
  logic                  arb_en;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  logic                  wen_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       data_q;

  // Reset also blocks grants so a transfer can never coincide with reset.
  assign arb_en = ~bus.hold & ~rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
`ifdef RF_WB_ARBITER_RR_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .req_i (bus.req_valid),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    xfer     = |gnt;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | bus.req_addr[i];
        sel_data = sel_data | bus.req_data[i];
      end
    end
  end

  // Writes to x0 are accepted but never enable the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= xfer && (sel_addr != '0);
      if (xfer) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
      end
    end
  end

  assign bus.rd_wen  = wen_q & ~rst;
  assign bus.rd_addr = rst ? '0 : addr_q;
  assign bus.rd_data = rst ? '0 : data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Vector-table bench for rf_wb_arbiter with a one-deep-per-cycle output scoreboard.
module tb_rf_wb_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  typedef struct {
    logic [NREQ-1:0]           valid;
    logic [NREQ-1:0][4:0]      addr;
    logic [NREQ-1:0][XLEN-1:0] data;
    logic                      hold;
    logic [NREQ-1:0]           exp_ready;
  } vec_t;

  typedef struct {
    logic            xfer;
    logic            wen;
    rf_pkg::wr_req_t req;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                              input logic [31:0] d0, d1, d2, input logic h,
                              input logic [2:0] rr_exp, input logic [2:0] fx_exp);
    vec_t t;
    t.valid = v;
    t.addr  = {a2, a1, a0};
    t.data  = {d2, d1, d0};
    t.hold  = h;
`ifdef RF_WB_ARBITER_RR_EN
    t.exp_ready = rr_exp;
`else
    t.exp_ready = fx_exp;
`endif
    return t;
  endfunction

  // Called just after a rising edge: drive, check at the falling edge, advance.
  task automatic cycle(input vec_t v);
    exp_t e;
    bus.req_valid = v.valid;
    bus.req_addr  = v.addr;
    bus.req_data  = v.data;
    bus.hold      = v.hold;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_wen", 32'(bus.rd_wen), 32'(e.wen));
      if (e.xfer) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(e.req.addr));
        chk("rd_data", bus.rd_data, e.req.data);
      end
    end else begin
      chk("rd_wen_idle", 32'(bus.rd_wen), 32'd0);
    end
    chk("req_ready", 32'(bus.req_ready), 32'(v.exp_ready));
    e = '{xfer: 1'b0, wen: 1'b0, req: '0};
    for (int i = 0; i < NREQ; i++) begin
      if (v.exp_ready[i]) begin
        e.xfer     = 1'b1;
        e.wen      = (v.addr[i] != 5'd0);
        e.req.addr = v.addr[i];
        e.req.data = v.data[i];
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t allv;

  initial begin
    idle = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 3'b000);
    allv = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2,
              1'b0, 3'b001, 3'b001);

    vecs.push_back(idle);
    vecs.push_back(mk(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 3'b001, 3'b001));
    vecs.push_back(mk(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 1'b0, 3'b010, 3'b010));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h5555, 1'b0, 3'b100, 3'b100));
    vecs.push_back(idle);
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b001, 3'b001));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b010, 3'b001));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b100, 3'b001));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b001, 3'b001));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b010, 3'b001));
    vecs.push_back(mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 1'b0, 3'b100, 3'b001));
    vecs.push_back(idle);
    // A write in the output stage still issues when hold rises behind it.
    vecs.push_back(mk(3'b001, 5'd3, 5'd0, 5'd0, 32'h3333, 32'h0, 32'h0, 1'b0, 3'b001, 3'b001));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h4444, 1'b1, 3'b000, 3'b000));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h4444, 1'b1, 3'b000, 3'b000));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h4444, 1'b1, 3'b000, 3'b000));
    vecs.push_back(mk(3'b100, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h4444, 1'b0, 3'b100, 3'b100));
    vecs.push_back(idle);
    vecs.push_back(mk(3'b110, 5'd0, 5'd6, 5'd7, 32'h0, 32'h6666, 32'h7777, 1'b0, 3'b010, 3'b010));
    vecs.push_back(mk(3'b101, 5'd8, 5'd0, 5'd7, 32'h8888, 32'h0, 32'h7777, 1'b0, 3'b100, 3'b001));
    vecs.push_back(idle);

    // Reset with every requester valid: no grants, outputs forced low.
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_addr  = allv.addr;
    bus.req_data  = allv.data;
    bus.hold      = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_wen", 32'(bus.rd_wen), 32'd0);
      chk("rst_addr", 32'(bus.rd_addr), 32'd0);
      chk("rst_data", bus.rd_data, 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    foreach (vecs[k]) cycle(vecs[k]);

    // Reset arriving behind a transfer suppresses it and rewinds the pointer.
    cycle(mk(3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 3'b001, 3'b001));
    rst = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("midrst_wen", 32'(bus.rd_wen), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(allv);
    cycle(idle);
    cycle(idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
